hazard_scoreboard: RTL

Parametrised hazard unit for the in-order 5-stage RISC-V core (F/D/E/M/W), replacing the purely combinational forwarding/stall logic. It keeps E-stage forwarding from M and W, the load-use stall and branch flush, and adds a registered scoreboard that tracks destination registers of an out-of-pipeline long-latency unit (mul/div), stalling D on RAW/WAW hazards until completion. It sits beside the pipeline registers and drives their stall/flush enables and the E-stage operand muxes.

---
 rtl/core_hazard_pkg.sv | 28 ++
 rtl/hazard_sb_tracker.sv | 99 +++++++++
 rtl/hazard_scoreboard.sv | 94 +++++++++
 3 files changed

// File: rtl/core_hazard_pkg.sv
// Shared hazard-unit types: forward-select encoding and register-index defaults.
// Imported by hazard_sb_tracker and hazard_scoreboard.
package core_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam int NUM_REGS_DEF = 32;
    localparam int REG_AW_DEF   = $clog2(NUM_REGS_DEF);

    // M is the younger producer, so it wins over W.
    function automatic fwd_sel_e fwd_pick(
        input logic hit_m,
        input logic hit_w
    );
        if (hit_m) begin
            return FWD_M;
        end
        if (hit_w) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_sb_tracker.sv
// Long-latency op tracker: in-flight counter plus (optionally) a per-register
// pending vector; produces sb_stall for D and full_stall for E.
// Ports: clk, rst_n (async low); D sources/dest; E issue + rd_e; lu_done/_rd;
// outputs sb_stall, full_stall, lu_busy.
// Macro HAZARD_SCOREBOARD_EN: per-register tracking; undefined -> one op max,
// any outstanding op stalls D.
module hazard_sb_tracker
    import core_hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int MAX_OUT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic              lu_issue_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              lu_done,
    input  logic [REG_AW-1:0] lu_done_rd,
    output logic              sb_stall,
    output logic              full_stall,
    output logic              lu_busy
);

`ifdef HAZARD_SCOREBOARD_EN
    localparam int MO = MAX_OUT;
`else
    localparam int MO = (MAX_OUT > 1) ? 1 : MAX_OUT;
`endif
    localparam int CW = $clog2(MO + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          issue_ok;
    logic          done_ok;

    // A completion in the same cycle frees a slot for the new issue.
    assign full_stall = lu_issue_e && (count_q == CW'(MO)) && !lu_done;
    assign issue_ok   = lu_issue_e && !full_stall;
    // Stale completions (e.g. after a mid-op reset) never underflow.
    assign done_ok    = lu_done && (count_q != '0);
    assign lu_busy    = (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (issue_ok && !done_ok) begin
            count_d = count_q + CW'(1);
        end else if (!issue_ok && done_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear first, then set, so a same-edge set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (done_ok) begin
            pending_d[lu_done_rd] = 1'b0;
        end
        if (issue_ok && (rd_e != '0)) begin
            pending_d[rd_e] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign sb_stall = ((rs1_d != '0) && pending_q[rs1_d])
                    | ((rs2_d != '0) && pending_q[rs2_d])
                    | (regwrite_d && (rd_d != '0) && pending_q[rd_d]);
`else
    logic unused_sb_ins;
    assign unused_sb_ins = ^{rs1_d, rs2_d, rd_d, regwrite_d, rd_e, lu_done_rd};

    assign sb_stall = lu_busy;
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: E-stage forwarding, load-use stall,
// branch flush, and a long-latency scoreboard (hazard_sb_tracker).
// Ports: M/W/E/D register ids and write enables, load_e, pcsrc_e, lu_issue_e,
// lu_done/_rd in; forward_a_e/_b_e, stall_f/d/e, flush_d/e, lu_busy out.
// Macro HAZARD_SCOREBOARD_EN selects per-register tracking (see tracker).
module hazard_scoreboard
    import core_hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int MAX_OUT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic              load_e,
    input  logic              pcsrc_e,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              lu_issue_e,
    input  logic              lu_done,
    input  logic [REG_AW-1:0] lu_done_rd,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              lu_busy
);

    logic     sb_stall;
    logic     full_stall;
    logic     lu_stall;
    logic     hold_fd;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    hazard_sb_tracker #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .MAX_OUT  (MAX_OUT)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rd_d       (rd_d),
        .regwrite_d (regwrite_d),
        .lu_issue_e (lu_issue_e),
        .rd_e       (rd_e),
        .lu_done    (lu_done),
        .lu_done_rd (lu_done_rd),
        .sb_stall   (sb_stall),
        .full_stall (full_stall),
        .lu_busy    (lu_busy)
    );

    always_comb begin
        fwd_a = fwd_pick(
            regwrite_m && (rs1_e == rd_m) && (rs1_e != '0),
            regwrite_w && (rs1_e == rd_w) && (rs1_e != '0));
        fwd_b = fwd_pick(
            regwrite_m && (rs2_e == rd_m) && (rs2_e != '0),
            regwrite_w && (rs2_e == rd_w) && (rs2_e != '0));
    end

    assign forward_a_e = fwd_a;
    assign forward_b_e = fwd_b;

    assign lu_stall = load_e && (rd_e != '0)
                    && ((rs1_d == rd_e) || (rs2_d == rd_e));

    // A taken branch kills F/D contents anyway, unless E itself is frozen.
    assign hold_fd = (lu_stall || sb_stall || full_stall)
                   && !(pcsrc_e && !full_stall);

    assign stall_f = hold_fd;
    assign stall_d = hold_fd;
    assign stall_e = full_stall;
    assign flush_d = pcsrc_e;
    // While E is held it must keep its instruction, so no bubble into E.
    assign flush_e = ((lu_stall || sb_stall) && !full_stall) || pcsrc_e;

endmodule
